vga_sync_decoder: RTL and testbench
===================================

// Module: vga_sync_decoder
// PURPOSE
//  Receive-side counterpart of the scope's VGA timing controller. Samples incoming h_sync/v_sync/RGB
//  and recovers pixel coordinates (x,y), a pixel-valid strobe and gated RGB. Measures line and frame
//  length and reports lock/timing errors. Used as display-path loopback checker and for capture of an
//  external VGA stream.
// PARAMETERS
//  H_TOTAL    800  expected clocks per line (falling h_sync to falling h_sync)
//  H_ACTIVE   640  active pixels per line
//  H_BACK     45   clocks from h_sync rising edge to first active pixel (x=0)
//  V_TOTAL    525  expected lines per frame (falling v_sync to falling v_sync)
//  V_ACTIVE   480  active lines per frame
//  V_BACK     29   lines from v_sync rising edge to first active line (y=0)
//  H_TOL      2    allowed +/- deviation of measured line length, in clocks
//  LOCK_LINES 4    consecutive in-tolerance lines needed for lock
// PORTS
//  clock        in   1   pixel clock; all logic on rising edge
//  reset        in   1   synchronous, active-high
//  h_sync       in   1   horizontal sync, active low
//  v_sync       in   1   vertical sync, active low
//  RGB          in   3   pixel colour {B,G,R}
//  x            out  10  recovered column 0..H_ACTIVE-1; 0 outside active window
//  y            out  10  recovered row 0..V_ACTIVE-1; 0 outside active window
//  pixel_valid  out  1   high when locked and (x,y) inside active window
//  rgb_out      out  3   RGB delayed to align with x/y; 0 when pixel_valid low
//  locked       out  1   high in LOCKED state
//  line_len     out  10  last measured line length in clocks
//  frame_lines  out  10  last measured lines per frame
//  timing_error out  1   single-cycle pulse on loss of lock
// BEHAVIOUR
//  - Reset: all outputs 0, state SEARCH, all counters 0, sync history registers 1 (idle high).
//  - Inputs registered once (hs_d, vs_d, rgb_d); edges from hs_d vs. hs_d2 (likewise v). Fall = 1->0.
//  - h_cnt: 0 on h_sync rising edge, else +1, saturating at 1023. Fully independent of lock.
//  - per_cnt: clocks since last h falling edge; on fall, line_len <= per_cnt+1, per_cnt <= 0.
//  - v_line: 0 on v_sync rising edge, +1 on each h_sync rising edge, saturating at 1023.
//  - frame_lines <= h falls counted since previous v falling edge; updated on each v fall.
//  - Active window: H_BACK <= h_cnt < H_BACK+H_ACTIVE and V_BACK <= v_line < V_BACK+V_ACTIVE.
//    x = h_cnt-H_BACK, y = v_line-V_BACK (10-bit unsigned).
//  - Outputs registered. Latency: input pin -> x/y/rgb_out/pixel_valid = 2 clocks.
//  - State machine:
//    SEARCH: first h fall -> VERIFY; good_cnt=0, v_seen=0.
//    VERIFY: on h fall, |line_len-H_TOTAL|<=H_TOL -> good_cnt+1, else good_cnt=0.
//      Any v fall -> v_seen=1. good_cnt>=LOCK_LINES and v_seen -> LOCKED.
//    LOCKED: exit to SEARCH with timing_error=1 for one clock when any of:
//      (a) line length out of tolerance; (b) v fall with frame_lines != V_TOTAL;
//      (c) h_cnt saturates (sync lost).
//  - Boundaries:
//    - h fall and v fall in same cycle: line checked first, then frame check; single error pulse.
//    - First frame after lock is measured with stale frame_lines: frame check (b) is skipped
//      until one full frame has completed in LOCKED.
//    - Error cycle forces pixel_valid=0 in the same cycle.
//    - Reset mid-frame: back to SEARCH. Relock needs >= LOCK_LINES lines plus a v_sync edge.
// TESTING
//  - Nominal 800x525 stream from the controller, from reset -> locked within first frame after v_sync;
//    line_len=800, frame_lines=525; pixel_valid count per frame = 640*480.
//  - Pixel at h_cnt=45, v_line=29 with RGB=3'b101 -> two clocks later x=0, y=0, rgb_out=3'b101,
//    pixel_valid=1.
//  - After lock, one line 806 clocks long -> timing_error pulse, locked=0; relock after 4 good
//    lines + v_sync.
//  - Line lengths 798 and 802 (within H_TOL) -> remain locked, no error.
//  - h_sync held high 1100 clocks while locked -> error at h_cnt saturation, state SEARCH,
//    pixel_valid=0.
//  - Assert reset mid-line while locked -> next clock all outputs 0; lock reacquired on
//    nominal stream.

Source files
------------

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_sync_decoder: recovers x/y, pixel-valid and gated RGB from a VGA stream|
// | and tracks line/frame timing lock.                       Revision: 1.0     |
// +----------------------------------------------------------------------------+
module vga_sync_decoder #(
  parameter int H_TOTAL    = 800,
  parameter int H_ACTIVE   = 640,
  parameter int H_BACK     = 45,
  parameter int V_TOTAL    = 525,
  parameter int V_ACTIVE   = 480,
  parameter int V_BACK     = 29,
  parameter int H_TOL      = 2,
  parameter int LOCK_LINES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [2:0] RGB,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_valid,
  output logic [2:0] rgb_out,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       timing_error
);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [9:0]  c_CNT_MAX    = 10'd1023;
  localparam logic [9:0]  c_H_BACK     = 10'(H_BACK);
  localparam logic [9:0]  c_H_END      = 10'(H_BACK + H_ACTIVE);
  localparam logic [9:0]  c_V_BACK     = 10'(V_BACK);
  localparam logic [9:0]  c_V_END      = 10'(V_BACK + V_ACTIVE);
  localparam logic [10:0] c_LINE_MIN   = 11'(H_TOTAL - H_TOL);
  localparam logic [10:0] c_LINE_MAX   = 11'(H_TOTAL + H_TOL);
  localparam logic [10:0] c_V_TOTAL    = 11'(V_TOTAL);
  localparam logic [7:0]  c_LOCK_LINES = 8'(LOCK_LINES);

  logic        r_hs_d, r_hs_d2, r_vs_d, r_vs_d2;
  logic [2:0]  r_rgb_d;
  logic [9:0]  r_h_cnt, r_v_line, r_per_cnt, r_frm_cnt;
  logic [7:0]  r_good_cnt, w_good_nxt;
  logic        r_v_seen, w_v_seen_nxt, r_armed, w_armed_nxt;
  state_t      r_state, w_state_nxt;
  logic        w_h_fall, w_h_rise, w_v_fall, w_v_rise;
  logic [9:0]  w_h_nxt, w_v_nxt, w_line_sat, w_frame_sat;
  logic [10:0] w_line_meas, w_frame_meas;
  logic        w_line_ok, w_frame_ok, w_in_win, w_valid, w_err;

  assign w_h_fall = r_hs_d2 & ~r_hs_d;
  assign w_h_rise = ~r_hs_d2 & r_hs_d;
  assign w_v_fall = r_vs_d2 & ~r_vs_d;
  assign w_v_rise = ~r_vs_d2 & r_vs_d;

  // Window decode uses the counter values being loaded this edge so that
  // x/y line up with the pixel held in r_rgb_d.
  assign w_h_nxt = w_h_rise ? 10'd0 :
                   (r_h_cnt == c_CNT_MAX) ? r_h_cnt : r_h_cnt + 10'd1;
  assign w_v_nxt = w_v_rise ? 10'd0 :
                   (w_h_rise && (r_v_line != c_CNT_MAX)) ? r_v_line + 10'd1 : r_v_line;

  assign w_line_meas  = {1'b0, r_per_cnt} + 11'd1;
  assign w_frame_meas = {1'b0, r_frm_cnt} + {10'd0, w_h_fall};
  assign w_line_sat   = w_line_meas[10] ? c_CNT_MAX : w_line_meas[9:0];
  assign w_frame_sat  = w_frame_meas[10] ? c_CNT_MAX : w_frame_meas[9:0];
  assign w_line_ok    = (w_line_meas >= c_LINE_MIN) && (w_line_meas <= c_LINE_MAX);
  assign w_frame_ok   = (w_frame_meas == c_V_TOTAL);

  assign w_in_win = (w_h_nxt >= c_H_BACK) && (w_h_nxt < c_H_END) &&
                    (w_v_nxt >= c_V_BACK) && (w_v_nxt < c_V_END);
  assign w_valid  = w_in_win && (w_state_nxt == LOCKED);
  assign locked   = (r_state == LOCKED);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= SEARCH;
      r_good_cnt <= 8'd0;
      r_v_seen   <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_v_seen   <= w_v_seen_nxt;
      r_armed    <= w_armed_nxt;
    end
  end

  // r_armed marks that a full frame has started inside LOCKED, so the frame
  // length check only runs against a frame measured entirely while locked.
  always_comb begin
    w_state_nxt  = r_state;
    w_good_nxt   = r_good_cnt;
    w_v_seen_nxt = r_v_seen;
    w_armed_nxt  = r_armed;
    w_err        = 1'b0;
    case (r_state)
      SEARCH: begin
        w_armed_nxt = 1'b0;
        if (w_h_fall) begin
          w_state_nxt  = VERIFY;
          w_good_nxt   = 8'd0;
          w_v_seen_nxt = 1'b0;
        end
      end
      VERIFY: begin
        if (w_h_fall) begin
          if (!w_line_ok)
            w_good_nxt = 8'd0;
          else if (r_good_cnt != 8'hFF)
            w_good_nxt = r_good_cnt + 8'd1;
        end
        if (w_v_fall)
          w_v_seen_nxt = 1'b1;
        if ((r_good_cnt >= c_LOCK_LINES) && r_v_seen) begin
          w_state_nxt = LOCKED;
          w_armed_nxt = 1'b0;
        end
      end
      LOCKED: begin
        if ((w_h_fall && !w_line_ok) || (w_v_fall && r_armed && !w_frame_ok) ||
            (w_h_nxt == c_CNT_MAX)) begin
          w_err       = 1'b1;
          w_state_nxt = SEARCH;
          w_armed_nxt = 1'b0;
        end else if (w_v_fall) begin
          w_armed_nxt = 1'b1;
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hs_d       <= 1'b1;
      r_hs_d2      <= 1'b1;
      r_vs_d       <= 1'b1;
      r_vs_d2      <= 1'b1;
      r_rgb_d      <= 3'd0;
      r_h_cnt      <= 10'd0;
      r_v_line     <= 10'd0;
      r_per_cnt    <= 10'd0;
      r_frm_cnt    <= 10'd0;
      line_len     <= 10'd0;
      frame_lines  <= 10'd0;
      x            <= 10'd0;
      y            <= 10'd0;
      pixel_valid  <= 1'b0;
      rgb_out      <= 3'd0;
      timing_error <= 1'b0;
    end else begin
      r_hs_d   <= h_sync;
      r_hs_d2  <= r_hs_d;
      r_vs_d   <= v_sync;
      r_vs_d2  <= r_vs_d;
      r_rgb_d  <= RGB;
      r_h_cnt  <= w_h_nxt;
      r_v_line <= w_v_nxt;

      if (w_h_fall) begin
        line_len  <= w_line_sat;
        r_per_cnt <= 10'd0;
      end else if (r_per_cnt != c_CNT_MAX) begin
        r_per_cnt <= r_per_cnt + 10'd1;
      end

      if (w_v_fall) begin
        frame_lines <= w_frame_sat;
        r_frm_cnt   <= 10'd0;
      end else if (w_h_fall && (r_frm_cnt != c_CNT_MAX)) begin
        r_frm_cnt <= r_frm_cnt + 10'd1;
      end

      x            <= w_in_win ? (w_h_nxt - c_H_BACK) : 10'd0;
      y            <= w_in_win ? (w_v_nxt - c_V_BACK) : 10'd0;
      pixel_valid  <= w_valid;
      rgb_out      <= w_valid ? r_rgb_d : 3'd0;
      timing_error <= w_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_sync_decoder: directed bench on a scaled-down 40x20 VGA timing.     |
// +----------------------------------------------------------------------------+
module tb_vga_sync_decoder;

  localparam int HT = 40, HA = 16, HB = 6, VT = 20, VA = 10, VB = 4, TOL = 2, LL = 4;
  localparam int HS_LOW = 4;  // sync-low clocks at the start of every line

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       h_sync = 1'b1;
  logic       v_sync = 1'b1;
  logic [2:0] RGB = 3'd0;
  logic [9:0] x, y, line_len, frame_lines;
  logic       pixel_valid, locked, timing_error;
  logic [2:0] rgb_out;

  int tests_run = 0;
  int tests_failed = 0;
  int pv_cnt = 0, err_cnt = 0, err_pv_cnt = 0;
  int probe_line = -1, probe_i = -1;
  logic [2:0] probe_rgb = 3'b101;
  logic [9:0] obs_x = '0, obs_y = '0;
  logic       obs_pv = 1'b0;
  logic [2:0] obs_rgb = '0;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_BACK(HB), .V_TOTAL(VT), .V_ACTIVE(VA),
    .V_BACK(VB), .H_TOL(TOL), .LOCK_LINES(LL)
  ) dut (
    .clock(clock), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .RGB(RGB),
    .x(x), .y(y), .pixel_valid(pixel_valid), .rgb_out(rgb_out), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines), .timing_error(timing_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (pixel_valid) pv_cnt++;
    if (timing_error) err_cnt++;
    if (timing_error && pixel_valid) err_pv_cnt++;
  end

  task automatic cyc(input logic h, input logic v, input logic [2:0] c);
    h_sync = h;
    v_sync = v;
    RGB    = c;
    @(negedge clock);
  endtask

  // Lines 0 and 1 of a frame carry v_sync low; line mod_line gets length mod_len.
  task automatic send_lines(input int first, input int last, input int mod_line, input int mod_len);
    for (int l = first; l <= last; l++) begin
      int len;
      len = (l == mod_line) ? mod_len : HT;
      for (int i = 0; i < len; i++) begin
        if (l == probe_line && i == probe_i + 2) begin
          obs_x = x; obs_y = y; obs_pv = pixel_valid; obs_rgb = rgb_out;
        end
        cyc(i >= HS_LOW, l >= 2, (l == probe_line && i == probe_i) ? probe_rgb : 3'b011);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++; if (x !== 10'd0) begin tests_failed++; $display("FAIL reset_x: got %0d expected 0", x); end
    tests_run++; if (y !== 10'd0) begin tests_failed++; $display("FAIL reset_y: got %0d expected 0", y); end
    tests_run++; if (pixel_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_pv: got %0d expected 0", pixel_valid); end
    tests_run++; if (rgb_out !== 3'd0) begin tests_failed++; $display("FAIL reset_rgb: got %0d expected 0", rgb_out); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked: got %0d expected 0", locked); end
    tests_run++; if (line_len !== 10'd0) begin tests_failed++; $display("FAIL reset_line_len: got %0d expected 0", line_len); end
    tests_run++; if (frame_lines !== 10'd0) begin tests_failed++; $display("FAIL reset_frame_lines: got %0d expected 0", frame_lines); end
    tests_run++; if (timing_error !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %0d expected 0", timing_error); end
    reset = 1'b0;
  endtask

  task automatic test_lock;
    send_lines(0, 10, -1, 0);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL lock_needs_vsync: got %0d expected 0", locked); end
    send_lines(11, VT - 1, -1, 0);
    send_lines(0, VT - 1, -1, 0);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL lock_acquired: got %0d expected 1", locked); end
    tests_run++; if (line_len !== 10'(HT)) begin tests_failed++; $display("FAIL lock_line_len: got %0d expected %0d", line_len, HT); end
    tests_run++; if (frame_lines !== 10'(VT)) begin tests_failed++; $display("FAIL lock_frame_lines: got %0d expected %0d", frame_lines, VT); end
    tests_run++; if (err_cnt !== 0) begin tests_failed++; $display("FAIL lock_no_error: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_pixel;
    int base;
    base = pv_cnt;
    probe_line = VB + 1; probe_i = HS_LOW + HB; probe_rgb = 3'b101;
    send_lines(0, VT - 1, -1, 0);
    probe_line = -1;
    tests_run++; if (obs_x !== 10'd0) begin tests_failed++; $display("FAIL first_pixel_x: got %0d expected 0", obs_x); end
    tests_run++; if (obs_y !== 10'd0) begin tests_failed++; $display("FAIL first_pixel_y: got %0d expected 0", obs_y); end
    tests_run++; if (obs_rgb !== 3'b101) begin tests_failed++; $display("FAIL first_pixel_rgb: got %0d expected 5", obs_rgb); end
    tests_run++; if (obs_pv !== 1'b1) begin tests_failed++; $display("FAIL first_pixel_pv: got %0d expected 1", obs_pv); end
    tests_run++; if (pv_cnt - base !== HA * VA) begin tests_failed++; $display("FAIL frame_pixel_count: got %0d expected %0d", pv_cnt - base, HA * VA); end
  endtask

  task automatic test_window_edges;
    int         pl [3];
    int         p_i [3];
    logic [9:0] ex [3];
    logic [9:0] ey [3];
    logic       epv [3];
    logic [2:0] ergb [3];
    pl = '{VB + 10, VB + 1, VB + 11};
    p_i = '{HS_LOW + HB + HA - 1, HS_LOW + HB - 1, HS_LOW + HB};
    ex = '{10'd15, 10'd0, 10'd0};
    ey = '{10'd9, 10'd0, 10'd0};
    epv = '{1'b1, 1'b0, 1'b0};
    ergb = '{3'b011, 3'b000, 3'b000};
    for (int k = 0; k < 3; k++) begin
      probe_line = pl[k]; probe_i = p_i[k]; probe_rgb = 3'b011;
      send_lines(0, VT - 1, -1, 0);
      probe_line = -1;
      tests_run++; if (obs_x !== ex[k]) begin tests_failed++; $display("FAIL edge%0d_x: got %0d expected %0d", k, obs_x, ex[k]); end
      tests_run++; if (obs_y !== ey[k]) begin tests_failed++; $display("FAIL edge%0d_y: got %0d expected %0d", k, obs_y, ey[k]); end
      tests_run++; if (obs_pv !== epv[k]) begin tests_failed++; $display("FAIL edge%0d_pv: got %0d expected %0d", k, obs_pv, epv[k]); end
      tests_run++; if (obs_rgb !== ergb[k]) begin tests_failed++; $display("FAIL edge%0d_rgb: got %0d expected %0d", k, obs_rgb, ergb[k]); end
    end
  endtask

  task automatic test_tolerance;
    int base;
    base = err_cnt;
    send_lines(0, 6, 5, HT - TOL);
    tests_run++; if (line_len !== 10'(HT - TOL)) begin tests_failed++; $display("FAIL tol_short_len: got %0d expected %0d", line_len, HT - TOL); end
    send_lines(7, 11, 10, HT + TOL);
    tests_run++; if (line_len !== 10'(HT + TOL)) begin tests_failed++; $display("FAIL tol_long_len: got %0d expected %0d", line_len, HT + TOL); end
    send_lines(12, VT - 1, -1, 0);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL tol_still_locked: got %0d expected 1", locked); end
    tests_run++; if (err_cnt - base !== 0) begin tests_failed++; $display("FAIL tol_no_error: got %0d expected 0", err_cnt - base); end
  endtask

  task automatic test_long_line;
    int base, base_pv;
    base = err_cnt; base_pv = err_pv_cnt;
    send_lines(0, 5, 5, HT + 6);
    send_lines(6, 6, -1, 0);
    tests_run++; if (err_cnt - base !== 1) begin tests_failed++; $display("FAIL long_err_pulse: got %0d expected 1", err_cnt - base); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL long_unlocked: got %0d expected 0", locked); end
    tests_run++; if (err_pv_cnt - base_pv !== 0) begin tests_failed++; $display("FAIL long_err_pv: got %0d expected 0", err_pv_cnt - base_pv); end
    send_lines(7, VT - 1, -1, 0);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL relock_waits_vsync: got %0d expected 0", locked); end
    send_lines(0, 1, -1, 0);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL relock_after_vsync: got %0d expected 1", locked); end
  endtask

  task automatic test_frame_error;
    int base;
    send_lines(2, VT - 1, -1, 0);
    send_lines(0, VT - 2, -1, 0);
    base = err_cnt;
    send_lines(0, 1, -1, 0);
    tests_run++; if (err_cnt - base !== 1) begin tests_failed++; $display("FAIL short_frame_err: got %0d expected 1", err_cnt - base); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL short_frame_unlock: got %0d expected 0", locked); end
    tests_run++; if (frame_lines !== 10'(VT - 1)) begin tests_failed++; $display("FAIL short_frame_lines: got %0d expected %0d", frame_lines, VT - 1); end
    send_lines(2, VT - 1, -1, 0);
    send_lines(0, 1, -1, 0);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL frame_relock: got %0d expected 1", locked); end
  endtask

  task automatic test_sync_loss;
    int base;
    base = err_cnt;
    for (int i = 0; i < 1100; i++) cyc(1'b1, 1'b1, 3'b011);
    tests_run++; if (err_cnt - base !== 1) begin tests_failed++; $display("FAIL hold_err_pulse: got %0d expected 1", err_cnt - base); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL hold_unlocked: got %0d expected 0", locked); end
    tests_run++; if (pixel_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_pv: got %0d expected 0", pixel_valid); end
  endtask

  task automatic test_reset_mid_line;
    send_lines(0, VT - 1, -1, 0);
    send_lines(0, 5, -1, 0);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_locked: got %0d expected 1", locked); end
    for (int i = 0; i < 13; i++) cyc(i >= HS_LOW, 1'b1, 3'b011);
    tests_run++; if (pixel_valid !== 1'b1 || x !== 10'd1 || y !== 10'd1) begin
      tests_failed++; $display("FAIL pre_reset_pixel: got pv=%0d x=%0d y=%0d expected pv=1 x=1 y=1", pixel_valid, x, y);
    end
    reset = 1'b1;
    cyc(1'b1, 1'b1, 3'b011);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_locked: got %0d expected 0", locked); end
    tests_run++; if (pixel_valid !== 1'b0 || x !== 10'd0 || y !== 10'd0 || rgb_out !== 3'd0) begin
      tests_failed++; $display("FAIL mid_reset_pixel: got pv=%0d x=%0d y=%0d rgb=%0d expected all 0", pixel_valid, x, y, rgb_out);
    end
    tests_run++; if (line_len !== 10'd0 || frame_lines !== 10'd0 || timing_error !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset_meas: got len=%0d frames=%0d err=%0d expected all 0", line_len, frame_lines, timing_error);
    end
    reset = 1'b0;
    for (int i = 14; i < HT; i++) cyc(1'b1, 1'b1, 3'b011);
    send_lines(7, VT - 1, -1, 0);
    send_lines(0, 1, -1, 0);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL reset_relock: got %0d expected 1", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixel();
    test_window_edges();
    test_tolerance();
    test_long_line();
    test_frame_error();
    test_sync_loss();
    test_reset_mid_line();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
